pck_len_ctrl: RTL and testbench
===============================

// Module: pck_len_ctrl
// PURPOSE
//  Upstream controller and pointer manager for pck_len_buffer (DEPTH x DATA_WIDTH length FIFO RAM).
//  Measures the byte length of each packet on the ingress beat stream (sop/eop framed).
//  On eop it writes the length into the buffer.
//  Owns the write/read pointers and full/empty, and serves length reads to the downstream packet reader.
// PARAMETERS
//  DATA_WIDTH 12 : packet length width in bytes; must match the buffer.
//  ADDR_WIDTH 5  : buffer index width; pointers are ADDR_WIDTH+1 bits (MSB = wrap bit).
//  DEPTH      32 : buffer entries; must equal 2**ADDR_WIDTH.
//  BPB        4  : bytes per ingress beat; must be a power of 2.
// PORTS
//  int_buffer_clk     in  1            : clock, shared with pck_len_buffer
//  int_buffer_rstn    in  1            : reset, asynchronous, active-low
//  int_buffer_sw_rstn in  1            : synchronous soft reset, active-high
//  pkt_valid_i        in  1            : ingress beat valid
//  pkt_sop_i          in  1            : first beat of packet (qualified by pkt_valid_i)
//  pkt_eop_i          in  1            : last beat of packet (qualified by pkt_valid_i)
//  pkt_last_bytes_i   in  $clog2(BPB)+1 : valid bytes in eop beat, 1..BPB
//  wr_en_o            out 1            : buffer write strobe
//  wr_addr_o          out ADDR_WIDTH+1 : write pointer
//  wr_data_o          out DATA_WIDTH   : packet length to store
//  rd_en_o            out 1            : buffer read strobe
//  rd_addr_o          out ADDR_WIDTH+1 : read pointer
//  buffer_full_o      out 1            : to buffer buffer_full and to status
//  buffer_empty_o     out 1            : to buffer buffer_empty and to status
//  len_rd_req_i       in  1            : downstream request for next length
//  len_vld_o          out 1            : buffer rd_data_o is valid this cycle (1-cycle pulse)
//  len_drop_o         out 1            : pulse: completed packet length discarded (full)
//  len_err_o          out 1            : pulse: framing error (sop in packet / eop or mid beat out of packet)
//  drop_cnt_o         out 16           : saturating count of len_drop_o pulses
// BEHAVIOUR
//  Reset (async rstn or sync sw_rstn):
//   - All outputs, pointers, accumulator and drop_cnt_o go to 0.
//   - FSM goes to IDLE; buffer_empty_o=1, buffer_full_o=0.
//   - sw_rstn has priority over all other inputs in the same cycle.
//  FSM IDLE/ACCUM, advanced only on pkt_valid_i beats:
//   IDLE, sop & !eop : acc <= BPB; go to ACCUM.
//   IDLE, sop & eop  : single-beat packet; length = pkt_last_bytes_i; stay in IDLE.
//   IDLE, !sop       : len_err_o=1; beat ignored.
//   ACCUM, !sop & !eop : acc <= acc + BPB.
//   ACCUM, eop         : length = acc + pkt_last_bytes_i; go to IDLE.
//   ACCUM, sop         : len_err_o=1; partial length discarded; restart as IDLE+sop in the same cycle.
//  Length arithmetic:
//   - Computed at DATA_WIDTH+1 bits.
//   - Saturates at 2**DATA_WIDTH-1 both in acc and in the final length.
//  Write, combinational on the eop beat:
//   - wr_en_o = eop_len_valid & !buffer_full_o.
//   - wr_data_o = final length; wr_addr_o = wr_ptr.
//   - wr_ptr increments at the same edge.
//   - If full at eop: no write, len_drop_o=1, drop_cnt_o++ (saturates at 16'hFFFF).
//  Read:
//   - rd_en_o = len_rd_req_i & !buffer_empty_o; rd_addr_o = rd_ptr.
//   - rd_ptr increments at the same edge.
//   - len_vld_o is a registered copy of rd_en_o: the buffer's rd_data_o is valid exactly 1 cycle after rd_en_o.
//   - A request while empty is ignored (no pulse). The downstream block must re-request.
//  Flags:
//   - full  = (wr_ptr[A]!=rd_ptr[A]) & (wr_ptr[A-1:0]==rd_ptr[A-1:0]).
//   - empty = (wr_ptr==rd_ptr).
//   - Both come from registered pointers, so the flags update 1 cycle after the pointer change.
//  Simultaneous write and read: both occur; occupancy is unchanged.
//   - When full, a read in the same cycle does NOT free space for that cycle's eop; the eop is dropped.
//   - When empty, a write in the same cycle is not readable until the next cycle.
//  Pointer wrap: 6-bit pointers roll over naturally; the MSB toggle differentiates full from empty.
// TESTING
//  1. 3-beat packet, last_bytes=2 (BPB=4) -> wr_en_o pulse, wr_data_o=10, wr_addr_o=0; next cycle empty_o=0.
//  2. Single-beat sop+eop, last_bytes=1 -> wr_data_o=1; len_rd_req_i -> rd_en_o, len_vld_o next cycle, rd_data=1.
//  3. 32 packets without reads -> full_o=1; 33rd eop -> no wr_en_o, len_drop_o=1, drop_cnt_o=1.
//  4. Full, then eop and len_rd_req_i in the same cycle -> read happens, eop dropped; afterwards occupancy=31.
//  5. sop, 2 mid beats, then sop again -> len_err_o=1; new packet length counts from the new sop only.
//  6. 40 write/read pairs -> pointers wrap 0x3F->0x00 correctly; sw_rstn mid-packet -> empty_o=1, acc=0.

Source files
------------

// File: rtl/pck_len_if.sv
// Ingress beat stream, length-buffer write/read strobes and status between
// pck_len_ctrl and its neighbours (packet source, pck_len_buffer, packet reader).
interface pck_len_if #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 5,
  parameter int BPB        = 4
);
  localparam int LBW = $clog2(BPB) + 1;

  logic                  pkt_valid_i;
  logic                  pkt_sop_i;
  logic                  pkt_eop_i;
  logic [LBW-1:0]        pkt_last_bytes_i;
  logic                  wr_en_o;
  logic [ADDR_WIDTH:0]   wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  rd_en_o;
  logic [ADDR_WIDTH:0]   rd_addr_o;
  logic                  buffer_full_o;
  logic                  buffer_empty_o;
  logic                  len_rd_req_i;
  logic                  len_vld_o;
  logic                  len_drop_o;
  logic                  len_err_o;
  logic [15:0]           drop_cnt_o;

  modport master (
    input  pkt_valid_i, pkt_sop_i, pkt_eop_i, pkt_last_bytes_i, len_rd_req_i,
    output wr_en_o, wr_addr_o, wr_data_o, rd_en_o, rd_addr_o,
           buffer_full_o, buffer_empty_o, len_vld_o, len_drop_o, len_err_o, drop_cnt_o
  );

  modport slave (
    output pkt_valid_i, pkt_sop_i, pkt_eop_i, pkt_last_bytes_i, len_rd_req_i,
    input  wr_en_o, wr_addr_o, wr_data_o, rd_en_o, rd_addr_o,
           buffer_full_o, buffer_empty_o, len_vld_o, len_drop_o, len_err_o, drop_cnt_o
  );
endinterface

// File: rtl/pck_len_ctrl.sv
// Packet length measurement and pointer management for the pck_len_buffer
// length FIFO: measures sop/eop framed packets, writes lengths, serves reads.
module pck_len_ctrl #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int BPB        = 4
) (
  input logic    int_buffer_clk,
  input logic    int_buffer_rstn,
  input logic    int_buffer_sw_rstn,
  pck_len_if.master bus
);

  localparam int LBW = $clog2(BPB) + 1;
  localparam logic [DATA_WIDTH:0] BPB_EXT   = (DATA_WIDTH+1)'(BPB);
  localparam logic [ADDR_WIDTH:0] DEPTH_PTR = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;
  logic                  len_vld_q, len_vld_d;

  logic                  eop_len_valid;
  logic [DATA_WIDTH-1:0] eop_len;
  logic                  len_err;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic                  rd_en;
  logic                  len_drop;
  logic [DATA_WIDTH:0]   last_bytes_ext;

  function automatic logic [DATA_WIDTH-1:0] sat_len(input logic [DATA_WIDTH:0] sum);
    return sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
  endfunction

  assign last_bytes_ext = {{(DATA_WIDTH+1-LBW){1'b0}}, bus.pkt_last_bytes_i};

  // Framing FSM and length accumulator; a sop always (re)starts a packet.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    eop_len_valid = 1'b0;
    eop_len       = {DATA_WIDTH{1'b0}};
    len_err       = 1'b0;
    if (int_buffer_sw_rstn) begin
      state_d = IDLE;
      acc_d   = {DATA_WIDTH{1'b0}};
    end else if (bus.pkt_valid_i) begin
      if (bus.pkt_sop_i) begin
        len_err = (state_q == ACCUM);
        if (bus.pkt_eop_i) begin
          eop_len_valid = 1'b1;
          eop_len       = sat_len(last_bytes_ext);
          state_d       = IDLE;
          acc_d         = {DATA_WIDTH{1'b0}};
        end else begin
          acc_d   = sat_len(BPB_EXT);
          state_d = ACCUM;
        end
      end else if (state_q == ACCUM) begin
        if (bus.pkt_eop_i) begin
          eop_len_valid = 1'b1;
          eop_len       = sat_len({1'b0, acc_q} + last_bytes_ext);
          state_d       = IDLE;
          acc_d         = {DATA_WIDTH{1'b0}};
        end else begin
          acc_d = sat_len({1'b0, acc_q} + BPB_EXT);
        end
      end else begin
        len_err = 1'b1;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Flags, strobes and next pointer/counter values; a read never frees space for a same-cycle eop.
  always_comb begin
    full       = ((wr_ptr_q - rd_ptr_q) == DEPTH_PTR);
    empty      = (wr_ptr_q == rd_ptr_q);
    wr_en      = eop_len_valid & ~full;
    len_drop   = eop_len_valid & full;
    rd_en      = bus.len_rd_req_i & ~empty & ~int_buffer_sw_rstn;
    wr_ptr_d   = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_en};
    rd_ptr_d   = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_en};
    len_vld_d  = rd_en;
    drop_cnt_d = drop_cnt_q;
    if (int_buffer_sw_rstn) begin
      wr_ptr_d   = {(ADDR_WIDTH+1){1'b0}};
      rd_ptr_d   = {(ADDR_WIDTH+1){1'b0}};
      drop_cnt_d = 16'h0000;
    end else if (len_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'h0001;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State, pointer and counter registers.
  always_ff @(posedge int_buffer_clk or negedge int_buffer_rstn) begin
    if (!int_buffer_rstn) begin
      state_q    <= IDLE;
      acc_q      <= {DATA_WIDTH{1'b0}};
      wr_ptr_q   <= {(ADDR_WIDTH+1){1'b0}};
      rd_ptr_q   <= {(ADDR_WIDTH+1){1'b0}};
      drop_cnt_q <= 16'h0000;
      len_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      len_vld_q  <= len_vld_d;
    end
  end

  assign bus.wr_en_o        = wr_en;
  assign bus.wr_addr_o      = wr_ptr_q;
  assign bus.wr_data_o      = eop_len;
  assign bus.rd_en_o        = rd_en;
  assign bus.rd_addr_o      = rd_ptr_q;
  assign bus.buffer_full_o  = full;
  assign bus.buffer_empty_o = empty;
  assign bus.len_vld_o      = len_vld_q;
  assign bus.len_drop_o     = len_drop;
  assign bus.len_err_o      = len_err;
  assign bus.drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_pck_len_ctrl.sv
// Randomized bench for pck_len_ctrl against a packet-level model: a length
// queue of capacity 32, write/read counts and a stand-in length buffer RAM.
module tb_pck_len_ctrl;

  localparam int BPB     = 4;
  localparam int MAX_LEN = 4095;
  localparam int CAP     = 32;

  logic clk;
  logic rst_n;
  logic sw_rst;

  pck_len_if #(.DATA_WIDTH(12), .ADDR_WIDTH(5), .BPB(BPB)) bus ();

  pck_len_ctrl #(.DATA_WIDTH(12), .ADDR_WIDTH(5), .DEPTH(32), .BPB(BPB)) dut (
    .int_buffer_clk     (clk),
    .int_buffer_rstn    (rst_n),
    .int_buffer_sw_rstn (sw_rst),
    .bus                (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // packet-level reference state
  bit in_pkt = 1'b0;
  int acc    = 0;
  int q[$];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int drops  = 0;
  bit vld_exp = 1'b0;
  int data_exp = 0;
  int rd_cap   = 0;
  int mem[CAP];

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive a beat/request, check against the model, advance the model.
  task automatic step(input bit v, input bit s, input bit e, input int lb, input bit req,
                      input bit srst = 1'b0);
    bit done, err_e, wr_e, drop_e, rd_e;
    int len;
    @(posedge clk);
    #1;
    bus.pkt_valid_i      = v;
    bus.pkt_sop_i        = s;
    bus.pkt_eop_i        = e;
    bus.pkt_last_bytes_i = 3'(lb);
    bus.len_rd_req_i     = req;
    sw_rst               = srst;
    #3;
    check_eq("len_vld", int'(bus.len_vld_o), int'(vld_exp));
    if (vld_exp) check_eq("rd_data", rd_cap, data_exp);
    check_eq("full", int'(bus.buffer_full_o), int'(q.size() == CAP));
    check_eq("empty", int'(bus.buffer_empty_o), int'(q.size() == 0));
    check_eq("wr_addr", int'(bus.wr_addr_o), wr_cnt % 64);
    check_eq("rd_addr", int'(bus.rd_addr_o), rd_cnt % 64);
    check_eq("drop_cnt", int'(bus.drop_cnt_o), drops);

    done = 1'b0; err_e = 1'b0; len = 0;
    if (!srst && v) begin
      if (s) begin
        err_e = in_pkt;
        if (e) begin
          done = 1'b1; len = lb; in_pkt = 1'b0;
        end else begin
          in_pkt = 1'b1; acc = BPB;
        end
      end else if (!in_pkt) begin
        err_e = 1'b1;
      end else if (e) begin
        done = 1'b1; len = acc + lb; in_pkt = 1'b0;
      end else begin
        acc += BPB;
      end
    end
    if (len > MAX_LEN) len = MAX_LEN;
    wr_e   = done && (q.size() < CAP);
    drop_e = done && (q.size() == CAP);
    rd_e   = !srst && req && (q.size() != 0);

    check_eq("wr_en", int'(bus.wr_en_o), int'(wr_e));
    check_eq("rd_en", int'(bus.rd_en_o), int'(rd_e));
    check_eq("len_drop", int'(bus.len_drop_o), int'(drop_e));
    check_eq("len_err", int'(bus.len_err_o), int'(err_e));
    if (wr_e) check_eq("wr_data", int'(bus.wr_data_o), len);

    // stand-in buffer: synchronous read of the DUT's address, then the DUT's write
    if (rd_e) rd_cap = mem[bus.rd_addr_o[4:0]];
    if (bus.wr_en_o) mem[bus.wr_addr_o[4:0]] = int'(bus.wr_data_o);

    if (srst) begin
      q.delete();
      in_pkt = 1'b0; acc = 0; wr_cnt = 0; rd_cnt = 0; drops = 0; vld_exp = 1'b0;
    end else begin
      vld_exp = rd_e;
      if (rd_e) begin
        data_exp = q.pop_front();
        rd_cnt++;
      end
      if (wr_e) begin
        q.push_back(len);
        wr_cnt++;
      end
      if (drop_e && drops < 65535) drops++;
    end
  endtask

  task automatic pkt(input int beats, input int lb, input bit req);
    for (int i = 0; i < beats; i++)
      step(1'b1, i == 0, i == beats - 1, lb, req);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, 1'b0, 1'b0, 1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < CAP; i++) mem[i] = 0;
    rst_n = 1'b0; sw_rst = 1'b0;
    bus.pkt_valid_i = 1'b0; bus.pkt_sop_i = 1'b0; bus.pkt_eop_i = 1'b0;
    bus.pkt_last_bytes_i = 3'd1; bus.len_rd_req_i = 1'b0;
    #12;
    check_eq("rst_empty", int'(bus.buffer_empty_o), 1);
    check_eq("rst_full", int'(bus.buffer_full_o), 0);
    check_eq("rst_wr_addr", int'(bus.wr_addr_o), 0);
    check_eq("rst_drop_cnt", int'(bus.drop_cnt_o), 0);
    check_eq("rst_len_vld", int'(bus.len_vld_o), 0);
    rst_n = 1'b1;

    // 3-beat packet of 10 bytes, then a single-beat packet read back
    pkt(3, 2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1, 1'b0);
    pkt(1, 1, 1'b0);
    drain();

    // sop inside a packet restarts counting; stray eop / mid beats flag errors
    step(1'b1, 1'b1, 1'b0, 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2, 1'b0);
    drain();

    // fill, overflow drop, then eop racing a read while full
    for (int i = 0; i < CAP; i++) pkt($urandom_range(1, 3), $urandom_range(1, 4), 1'b0);
    pkt(2, 4, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1, 1'b0);
    drain();

    // write/read pairs to wrap the pointers
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b1, $urandom_range(1, 4), 1'b0);
      step(1'b0, 1'b0, 1'b0, 1, 1'b1);
    end

    // saturating length
    pkt(1100, 4, 1'b0);
    drain();

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
           $urandom_range(1, 4), $urandom_range(0, 9) < 4);

    // soft reset mid-packet with active inputs; a following bare eop is a framing error
    step(1'b1, 1'b1, 1'b0, 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2, 1'b0);
    pkt(2, 3, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
